exponent_align_pipe: RTL

Two-stage pipelined exponent-compare and mantissa-alignment unit for the Add_Sub datapath, with valid/ready handshakes on both sides. It generalises the combinational exponent-difference block into a registered stage. Parameters set exponent and mantissa width. It adds operand swapping, guard/round/sticky alignment shifting, shift saturation and backpressure. It sits between operand unpacking and the significand adder.

---
 rtl/exponent_align_pipe_if.sv | 34 +++
 rtl/exponent_align_pipe.sv | 103 ++++++++++
 2 files changed

// File: rtl/exponent_align_pipe_if.sv
// Handshake and operand/result bundle for the exponent-align pipe.
// slave is the pipe itself; master is whoever drives operands and OutReady.
interface exponent_align_pipe_if #(
  parameter int ExponentSize = 8,
  parameter int MantissaSize = 24
);
  logic                      InValid;
  logic                      InReady;
  logic [ExponentSize-1:0]   Exponent1;
  logic [ExponentSize-1:0]   Exponent2;
  logic [MantissaSize-1:0]   Mantissa1;
  logic [MantissaSize-1:0]   Mantissa2;
  logic                      OutValid;
  logic                      OutReady;
  logic [ExponentSize-1:0]   Difference;
  logic                      Sign;
  logic                      ZeroFlag;
  logic [ExponentSize-1:0]   LargeExponent;
  logic [MantissaSize-1:0]   LargeMantissa;
  logic [MantissaSize+2:0]   AlignedMantissa;
  logic                      Saturated;

  modport slave (
    input  InValid, Exponent1, Exponent2, Mantissa1, Mantissa2, OutReady,
    output InReady, OutValid, Difference, Sign, ZeroFlag, LargeExponent,
           LargeMantissa, AlignedMantissa, Saturated
  );

  modport master (
    output InValid, Exponent1, Exponent2, Mantissa1, Mantissa2, OutReady,
    input  InReady, OutValid, Difference, Sign, ZeroFlag, LargeExponent,
           LargeMantissa, AlignedMantissa, Saturated
  );
endinterface

// File: rtl/exponent_align_pipe.sv
// Two-stage exponent compare / mantissa align for the add-sub datapath.
// Stage 1 orders the operands by exponent; stage 2 right-shifts the smaller
// significand (with guard/round/sticky) by the exponent difference.
module exponent_align_pipe #(
  parameter int ExponentSize = 8,
  parameter int MantissaSize = 24
) (
  input logic Clock,
  input logic ResetN,
  exponent_align_pipe_if.slave bus
);
  localparam int ExtSize = MantissaSize + 3;

  logic                    s1_valid;
  logic                    s1_sign;
  logic [ExponentSize-1:0] s1_diff;
  logic                    s1_zero;
  logic [ExponentSize-1:0] s1_lexp;
  logic [MantissaSize-1:0] s1_lman;
  logic [MantissaSize-1:0] s1_sman;

  logic                    s2_adv;
  logic                    in_sign;
  logic [ExponentSize-1:0] in_diff;

  logic [ExtSize-1:0]      ext;
  logic [ExtSize-1:0]      shifted;
  logic [ExtSize-1:0]      lost_mask;
  logic [ExtSize-1:0]      aligned_next;
  logic                    sat_next;

  // Stage 1 can always move when stage 2 moves; an empty stage 2 always moves.
  assign s2_adv      = !bus.OutValid || bus.OutReady;
  assign bus.InReady = !s1_valid || s2_adv;

  // Operand ordering: equal exponents keep operand 1 as the large one.
  always_comb begin
    in_sign = bus.Exponent2 > bus.Exponent1;
    in_diff = in_sign ? (bus.Exponent2 - bus.Exponent1)
                      : (bus.Exponent1 - bus.Exponent2);
  end

  // Alignment shift; the full difference is compared so large exponents never wrap.
  always_comb begin
    ext       = {s1_sman, 3'b000};
    sat_next  = 32'(s1_diff) >= 32'(ExtSize);
    shifted   = ext >> s1_diff;
    lost_mask = ~({ExtSize{1'b1}} << s1_diff);
    if (sat_next) begin
      aligned_next = {{(ExtSize-1){1'b0}}, |s1_sman};
    end else begin
      aligned_next = {shifted[ExtSize-1:1], shifted[0] | (|(ext & lost_mask))};
    end
  end

  // Compare stage register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_diff  <= '0;
      s1_zero  <= 1'b0;
      s1_lexp  <= '0;
      s1_lman  <= '0;
      s1_sman  <= '0;
    end else if (bus.InReady) begin
      s1_valid <= bus.InValid;
      if (bus.InValid) begin
        s1_sign <= in_sign;
        s1_diff <= in_diff;
        s1_zero <= bus.Exponent1 == bus.Exponent2;
        s1_lexp <= in_sign ? bus.Exponent2 : bus.Exponent1;
        s1_lman <= in_sign ? bus.Mantissa2 : bus.Mantissa1;
        s1_sman <= in_sign ? bus.Mantissa1 : bus.Mantissa2;
      end
    end
  end

  // Align stage / output register; held while the consumer stalls.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      bus.OutValid        <= 1'b0;
      bus.Sign            <= 1'b0;
      bus.Difference      <= '0;
      bus.ZeroFlag        <= 1'b0;
      bus.LargeExponent   <= '0;
      bus.LargeMantissa   <= '0;
      bus.AlignedMantissa <= '0;
      bus.Saturated       <= 1'b0;
    end else if (s2_adv) begin
      bus.OutValid <= s1_valid;
      if (s1_valid) begin
        bus.Sign            <= s1_sign;
        bus.Difference      <= s1_diff;
        bus.ZeroFlag        <= s1_zero;
        bus.LargeExponent   <= s1_lexp;
        bus.LargeMantissa   <= s1_lman;
        bus.AlignedMantissa <= aligned_next;
        bus.Saturated       <= sat_next;
      end
    end
  end
endmodule
